// File: rtl/pwm_voice_pkg.sv
// Shared definitions for the PWM voice: waveform encodings, parameter defaults
// and the phase-to-sample shaper.
package pwm_voice_pkg;

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'b00,
        WAVE_SAW    = 2'b01,
        WAVE_TRI    = 2'b10,
        WAVE_PULSE  = 2'b11
    } wave_t;

    localparam logic [7:0]  TOP_RESET_DEFAULT = 8'd255;
    localparam int unsigned ENV_SHIFT_DEFAULT = 5;

    function automatic logic [7:0] shape_sample(input logic [31:0] ph, input wave_t sel);
        logic [7:0] s;
        s = '0;
        unique case (sel)
            WAVE_SQUARE: s = ph[31] ? 8'hFF : 8'h00;
            WAVE_SAW:    s = ph[31:24];
            WAVE_TRI:    s = ph[31] ? ~ph[30:23] : ph[30:23];
            WAVE_PULSE:  s = (ph[31:29] == 3'b000) ? 8'hFF : 8'h00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/pwm_duty_counter.sv
// PWM period counter with double-buffered top and duty; both change only at
// the wrap edge so the audio output never glitches mid-period.
module pwm_duty_counter
    import pwm_voice_pkg::*;
#(
    parameter logic [7:0] TOP_RESET = TOP_RESET_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_top,
    input  logic        i_top_valid,
    input  logic [16:0] i_scaled,
    output logic        o_pwm,
    output logic        o_period_start
);

    logic [7:0] count;
    logic [7:0] top_active;
    logic [7:0] top_pending;
    logic [8:0] compare;

    logic       wrap;
    logic [7:0] new_top;
    logic [8:0] top_plus_one;
    logic [8:0] clamped;

    // A valid arriving on the wrap edge bypasses the pending register.
    always_comb begin
        wrap         = (count == top_active);
        new_top      = i_top_valid ? i_top : top_pending;
        top_plus_one = {1'b0, new_top} + 9'd1;
        clamped      = (i_scaled > 17'(top_plus_one)) ? top_plus_one : i_scaled[8:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count          <= '0;
            top_active     <= TOP_RESET;
            top_pending    <= TOP_RESET;
            compare        <= '0;
            o_pwm          <= 1'b0;
            o_period_start <= 1'b0;
        end else begin
            if (i_top_valid)
                top_pending <= i_top;
            if (wrap) begin
                count      <= '0;
                top_active <= new_top;
                compare    <= clamped;
            end else begin
                count <= count + 8'd1;
            end
            o_pwm          <= ({1'b0, count} < compare);
            o_period_start <= wrap;
        end
    end

endmodule

// File: rtl/pwm_voice.sv
// Single PWM audio voice: DDS phase accumulator, waveform shaper and envelope
// scaler feeding a double-buffered PWM duty counter.
module pwm_voice
    import pwm_voice_pkg::*;
#(
    parameter logic [7:0]  TOP_RESET = TOP_RESET_DEFAULT,
    parameter int unsigned ENV_SHIFT = ENV_SHIFT_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_top,
    input  logic        i_top_valid,
    input  logic [31:0] i_phase_delta,
    input  logic [8:0]  i_envelope,
    input  logic [1:0]  i_wave_sel,
    output logic        o_pwm,
    output logic        o_period_start
);

    logic [31:0] phase;
    logic [7:0]  sample;
    logic [16:0] scaled;
    logic [16:0] product;
    logic        rest;

    // Full 17-bit product is kept; the clamp downstream handles overrange.
    always_comb begin
        rest    = (i_phase_delta == '0);
        product = 17'(sample) * 17'(i_envelope);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase  <= '0;
            sample <= '0;
            scaled <= '0;
        end else begin
            if (!rest)
                phase <= phase + i_phase_delta;
            sample <= rest ? '0 : shape_sample(phase, wave_t'(i_wave_sel));
            scaled <= product >> ENV_SHIFT;
        end
    end

    pwm_duty_counter #(
        .TOP_RESET (TOP_RESET)
    ) u_duty (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_top          (i_top),
        .i_top_valid    (i_top_valid),
        .i_scaled       (scaled),
        .o_pwm          (o_pwm),
        .o_period_start (o_period_start)
    );

endmodule

// File: tb/tb_pwm_voice.sv
// Bench for pwm_voice: arithmetic reference model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_pwm_voice;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  top = 8'd0;
    logic        top_valid = 1'b0;
    logic [31:0] delta = 32'd0;
    logic [8:0]  env = 9'd0;
    logic [1:0]  wave = 2'd0;
    logic        pwm;
    logic        pstart;

    int tests = 0;
    int fails = 0;

    pwm_voice dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_top          (top),
        .i_top_valid    (top_valid),
        .i_phase_delta  (delta),
        .i_envelope     (env),
        .i_wave_sel     (wave),
        .o_pwm          (pwm),
        .o_period_start (pstart)
    );

    always #5 clk = ~clk;

    // Reference model: phase as an integer, sample by arithmetic on it,
    // period tracked as position/length.
    localparam longint HALF = 64'h8000_0000;

    function automatic int shape(input longint p, input int w);
        int t;
        case (w)
            0: return (p >= HALF) ? 255 : 0;
            1: return int'(p / (64'd1 << 24));
            2: begin
                t = int'((p / (64'd1 << 23)) % 256);
                return (p >= HALF) ? 255 - t : t;
            end
            default: return (p < (64'd1 << 29)) ? 255 : 0;
        endcase
    endfunction

    longint m_phase;
    int m_sample, m_scaled, m_pos, m_len, m_pending, m_duty;
    bit m_pwm, m_start;
    int new_top;
    bit m_wrap;

    always_comb begin
        m_wrap  = (m_pos == m_len - 1);
        new_top = top_valid ? int'(top) : m_pending;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase   <= 0;
            m_sample  <= 0;
            m_scaled  <= 0;
            m_pos     <= 0;
            m_len     <= 256;
            m_pending <= 255;
            m_duty    <= 0;
            m_pwm     <= 1'b0;
            m_start   <= 1'b0;
        end else begin
            if (delta != 0)
                m_phase <= (m_phase + longint'(delta)) % (64'd1 << 32);
            m_sample  <= (delta == 0) ? 0 : shape(m_phase, int'(wave));
            m_scaled  <= (m_sample * int'(env)) / 32;
            m_pending <= new_top;
            if (m_wrap) begin
                m_pos  <= 0;
                m_len  <= new_top + 1;
                m_duty <= (m_scaled < new_top + 1) ? m_scaled : new_top + 1;
            end else begin
                m_pos <= m_pos + 1;
            end
            m_pwm   <= (m_pos < m_duty);
            m_start <= m_wrap;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("pwm_vs_model", int'(pwm), int'(m_pwm));
            check("start_vs_model", int'(pstart), int'(m_start));
        end
    end

    task automatic wait_start(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pstart && n < 2000);
        if (!pstart) check("wait_start_timeout", 0, 1);
    endtask

    task automatic count_high(input int cycles, output int h);
        h = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (pwm) h++;
        end
    endtask

    task automatic phase_high();
        delta = 32'h8000_0000;
        @(negedge clk);
        delta = 32'd1;
    endtask

    initial begin
        int n, h, s;

        // Reset and rest: no output, first pulse 256 cycles after release.
        env = 9'd32;
        repeat (3) @(negedge clk);
        check("reset_pwm", int'(pwm), 0);
        check("reset_start", int'(pstart), 0);
        rst_n = 1'b1;
        wait_start(n);
        check("first_start_after_reset", n, 256);
        wait_start(n);
        check("rest_period_len", n, 256);

        // Square held high, half gain: 127 of 256 cycles high.
        wave = 2'd0;
        env  = 9'd16;
        phase_high();
        wait_start(n);
        wait_start(n);
        count_high(256, h);
        check("env16_high_cycles", h, 127);
        check("model_duty_env16", m_duty, 127);

        // Top change mid-period takes effect only at the next wrap.
        env = 9'd32;
        wait_start(n);
        wait_start(n);
        repeat (50) @(negedge clk);
        top = 8'd9;
        top_valid = 1'b1;
        @(negedge clk);
        top_valid = 1'b0;
        wait_start(n);
        check("period_len_before_top9", n + 51, 256);
        wait_start(n);
        check("period_len_top9", n, 10);
        check("model_len_top9", m_len, 10);
        count_high(10, h);
        check("top9_clamped_high", h, 10);

        // Overrange envelope clamps to full-on.
        env = 9'd511;
        top = 8'd255;
        top_valid = 1'b1;
        @(negedge clk);
        top_valid = 1'b0;
        wait_start(n);
        wait_start(n);
        check("period_len_top255", n, 256);
        count_high(256, h);
        check("env511_high_cycles", h, 256);

        // top=0 loaded on the wrap edge itself: 1-cycle periods.
        repeat (255) @(negedge clk);
        top = 8'd0;
        top_valid = 1'b1;
        @(negedge clk);
        top_valid = 1'b0;
        s = 0;
        h = 0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            if (pstart) s++;
            if (pwm) h++;
        end
        check("top0_start_held", s, 20);
        check("top0_pwm_high", h, 20);

        // Envelope zero silences the output.
        env = 9'd0;
        repeat (4) @(negedge clk);
        count_high(20, h);
        check("env0_silent", h, 0);

        // Randomized stimulus against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 3))
                    0: delta = 32'd0;
                    1: delta = $urandom;
                    2: delta = 32'($urandom_range(1, 1 << 26));
                    default: delta = 32'h0100_0000;
                endcase
                env  = 9'($urandom_range(0, 511));
                wave = 2'($urandom_range(0, 3));
            end
            top_valid = ($urandom_range(0, 39) == 0);
            top = 8'($urandom_range(0, 40));
            @(negedge clk);
        end
        top_valid = 1'b0;

        // Asynchronous reset mid-period.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wave = 2'd0;
        env  = 9'd511;
        wait_start(n);
        check("start_after_reset2", n, 256);
        phase_high();
        wait_start(n);
        wait_start(n);
        repeat (100) @(negedge clk);
        check("pwm_high_before_reset", int'(pwm), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_pwm", int'(pwm), 0);
        check("async_reset_start", int'(pstart), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_start(n);
        check("first_start_after_async_reset", n, 256);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
